game_screen_sequencer: RTL and testbench

Controller that sequences the game's OLED screen pages. It replaces the free-running btnR/sw next-state logic with conditioned buttons, forward/back navigation, optional auto-advance and a frame-aligned blanking transition. It outputs a 0-based screen index to the per-screen oled_data mux and a blank flag that forces BLACK during transitions.

---
 rtl/game_screen_sequencer_if.sv | 22 ++
 rtl/game_screen_sequencer.sv | 162 ++++++++++++++++
 tb/tb_game_screen_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_screen_sequencer_if.sv
// Screen sequencer bus: raw controls in, screen selection and blanking out.
interface game_screen_sequencer_if;
  logic       sw;
  logic       btnR;
  logic       btnL;
  logic       frame_tick;
  logic [3:0] screen_idx;
  logic       blank;
  logic       active;
  logic       at_last;
  logic       change;

  modport master (
    output sw, btnR, btnL, frame_tick,
    input  screen_idx, blank, active, at_last, change
  );

  modport slave (
    input  sw, btnR, btnL, frame_tick,
    output screen_idx, blank, active, at_last, change
  );
endinterface

// File: rtl/game_screen_sequencer.sv
// OLED screen page sequencer: synchronized/debounced buttons, forward/back
// navigation with optional wrap, optional auto-advance and frame-aligned blanking.
module game_screen_sequencer #(
  parameter int NUM_SCREENS     = 13,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLANK_FRAMES    = 4,
  parameter int AUTO_FRAMES     = 0,
  parameter int WRAP            = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  game_screen_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam int AW = (AUTO_FRAMES > 0) ? $clog2(AUTO_FRAMES + 1) : 1;
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLANK_FRAMES - 1);
  localparam logic [AW-1:0] FCNT_MAX = AW'(AUTO_FRAMES - 1);
  localparam logic [3:0]    IDX_LAST = 4'(NUM_SCREENS - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  logic [1:0]         r_sw_s;
  logic [1:0]         r_btn_s1, r_btn_s2;   // bit 0 = btnR, bit 1 = btnL
  logic [1:0]         r_acc, r_acc_d;
  logic [1:0][DW-1:0] r_dcnt;
  state_t             r_state;
  logic [3:0]         r_idx;
  logic               r_blank, r_active, r_change;
  logic [BW-1:0]      r_bcnt;
  logic [AW-1:0]      r_fcnt;

  logic       w_sw, w_pn, w_pp, w_auto, w_last, w_first, w_ev;
  logic [3:0] w_tgt, w_next, w_prev;
  logic       w_next_ok, w_prev_ok;

  assign w_sw   = r_sw_s[1];
  assign w_pn   = r_acc[0] & ~r_acc_d[0];
  assign w_pp   = r_acc[1] & ~r_acc_d[1];
  assign w_auto = (AUTO_FRAMES != 0) && bus.frame_tick && (r_fcnt == FCNT_MAX);

  assign w_last    = (r_idx == IDX_LAST);
  assign w_first   = (r_idx == 4'd0);
  assign w_next    = w_last  ? 4'd0     : r_idx + 4'd1;
  assign w_prev    = w_first ? IDX_LAST : r_idx - 4'd1;
  assign w_next_ok = !w_last  || (WRAP != 0);
  assign w_prev_ok = !w_first || (WRAP != 0);

  // Event arbitration: a lone button wins; a double press cancels everything,
  // auto only fires when no button is pressed.
  always_comb begin
    w_ev  = 1'b0;
    w_tgt = r_idx;
    if (w_pn && !w_pp) begin
      w_ev  = w_next_ok;
      w_tgt = w_next;
    end else if (w_pp && !w_pn) begin
      w_ev  = w_prev_ok;
      w_tgt = w_prev;
    end else if (!w_pn && !w_pp && w_auto) begin
      w_ev  = w_next_ok;
      w_tgt = w_next;
    end
  end

  // Input synchronizers and button debounce (accepted level flips after a
  // full run of disagreeing synced samples).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sw_s   <= '0;
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_acc    <= '0;
      r_acc_d  <= '0;
      r_dcnt   <= '0;
    end else begin
      r_sw_s   <= {r_sw_s[0], bus.sw};
      r_btn_s1 <= {bus.btnL, bus.btnR};
      r_btn_s2 <= r_btn_s1;
      r_acc_d  <= r_acc;
      for (int b = 0; b < 2; b++) begin
        if (r_btn_s2[b] != r_acc[b]) begin
          if (r_dcnt[b] == DCNT_MAX) begin
            r_acc[b]  <= r_btn_s2[b];
            r_dcnt[b] <= '0;
          end else begin
            r_dcnt[b] <= r_dcnt[b] + 1'b1;
          end
        end else begin
          r_dcnt[b] <= '0;
        end
      end
    end
  end

  // Screen FSM with registered outputs; disable overrides every state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_idx    <= 4'd0;
      r_blank  <= 1'b1;
      r_active <= 1'b0;
      r_change <= 1'b0;
      r_bcnt   <= '0;
      r_fcnt   <= '0;
    end else begin
      r_change <= 1'b0;
      if (!w_sw) begin
        r_state  <= IDLE;
        r_idx    <= 4'd0;
        r_blank  <= 1'b1;
        r_active <= 1'b0;
        r_bcnt   <= '0;
        r_fcnt   <= '0;
        r_change <= (r_idx != 4'd0);
      end else begin
        case (r_state)
          IDLE: begin
            r_state  <= SHOW;
            r_blank  <= 1'b0;
            r_active <= 1'b1;
            r_fcnt   <= '0;
          end
          SHOW: begin
            if (w_ev) begin
              r_idx    <= w_tgt;
              r_change <= 1'b1;
              r_fcnt   <= '0;
              if (BLANK_FRAMES != 0) begin
                r_state <= BLANK;
                r_blank <= 1'b1;
                r_bcnt  <= '0;
              end
            end else if ((AUTO_FRAMES != 0) && bus.frame_tick) begin
              r_fcnt <= (r_fcnt == FCNT_MAX) ? '0 : r_fcnt + 1'b1;
            end
          end
          BLANK: begin
            if (bus.frame_tick) begin
              if (r_bcnt == BCNT_MAX) begin
                r_state <= SHOW;
                r_blank <= 1'b0;
                r_bcnt  <= '0;
                r_fcnt  <= '0;
              end else begin
                r_bcnt <= r_bcnt + 1'b1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.screen_idx = r_idx;
  assign bus.blank      = r_blank;
  assign bus.active     = r_active;
  assign bus.change     = r_change;
  assign bus.at_last    = (r_idx == IDX_LAST);
endmodule

// File: tb/tb_game_screen_sequencer.sv
// Bench for game_screen_sequencer: three configurations (default, no-wrap,
// auto-advance without blanking) driven from shared inputs and compared every
// cycle against a rule-level reference model, plus directed spot checks.
module tb_game_screen_sequencer;
  localparam int NS  = 13;
  localparam int DEB = 16;
  localparam int BF [3] = '{4, 4, 0};
  localparam int AF [3] = '{0, 0, 3};
  localparam int WR [3] = '{1, 0, 1};
  localparam int M_IDLE = 0, M_SHOW = 1, M_BLANK = 2;

  logic clk, reset, sw, btnR, btnL, ft;
  int   npass, ntot;

  game_screen_sequencer_if ifa();
  game_screen_sequencer_if ifb();
  game_screen_sequencer_if ifc();

  assign ifa.sw = sw; assign ifa.btnR = btnR; assign ifa.btnL = btnL; assign ifa.frame_tick = ft;
  assign ifb.sw = sw; assign ifb.btnR = btnR; assign ifb.btnL = btnL; assign ifb.frame_tick = ft;
  assign ifc.sw = sw; assign ifc.btnR = btnR; assign ifc.btnL = btnL; assign ifc.frame_tick = ft;

  game_screen_sequencer #(.NUM_SCREENS(NS), .DEBOUNCE_CYCLES(DEB), .BLANK_FRAMES(4),
    .AUTO_FRAMES(0), .WRAP(1)) dut_a (.clk(clk), .reset(reset), .bus(ifa.slave));
  game_screen_sequencer #(.NUM_SCREENS(NS), .DEBOUNCE_CYCLES(DEB), .BLANK_FRAMES(4),
    .AUTO_FRAMES(0), .WRAP(0)) dut_b (.clk(clk), .reset(reset), .bus(ifb.slave));
  game_screen_sequencer #(.NUM_SCREENS(NS), .DEBOUNCE_CYCLES(DEB), .BLANK_FRAMES(0),
    .AUTO_FRAMES(3), .WRAP(1)) dut_c (.clk(clk), .reset(reset), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit hsw [2], hr [2], hl [2];   // raw samples: [0] last edge, [1] two edges ago
  bit accR, accL, accRd, accLd;
  int runR, runL;
  int mode [3], idx [3], mblank [3], mactive [3], mchange [3], bcnt [3], fcnt [3];

  task automatic chk(input string tag, input int got, input int exp);
    ntot++;
    if (got == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin hsw[i] = 0; hr[i] = 0; hl[i] = 0; end
    accR = 0; accL = 0; accRd = 0; accLd = 0; runR = 0; runL = 0;
    for (int m = 0; m < 3; m++) begin
      mode[m] = M_IDLE; idx[m] = 0; mblank[m] = 1; mactive[m] = 0;
      mchange[m] = 0; bcnt[m] = 0; fcnt[m] = 0;
    end
  endtask

  // One clock edge of the specified behaviour, using values seen before the edge.
  task automatic model_tick();
    bit pn, pp, sws, autoh;
    int tgt, nxt, prv;
    pn  = accR && !accRd;
    pp  = accL && !accLd;
    sws = hsw[1];
    for (int m = 0; m < 3; m++) begin
      mchange[m] = 0;
      if (!sws) begin
        mchange[m] = (idx[m] != 0);
        idx[m] = 0; mode[m] = M_IDLE; mblank[m] = 1; mactive[m] = 0;
        bcnt[m] = 0; fcnt[m] = 0;
      end else if (mode[m] == M_IDLE) begin
        mode[m] = M_SHOW; mblank[m] = 0; mactive[m] = 1; fcnt[m] = 0;
      end else if (mode[m] == M_SHOW) begin
        nxt   = (idx[m] == NS - 1) ? (WR[m] != 0 ? 0 : -1) : idx[m] + 1;
        prv   = (idx[m] == 0) ? (WR[m] != 0 ? NS - 1 : -1) : idx[m] - 1;
        autoh = (AF[m] != 0) && ft && (fcnt[m] + 1 == AF[m]);
        tgt   = -1;
        if (pn && !pp) tgt = nxt;
        else if (pp && !pn) tgt = prv;
        else if (!pn && !pp && autoh) tgt = nxt;
        if (tgt >= 0) begin
          idx[m] = tgt; mchange[m] = 1; fcnt[m] = 0;
          if (BF[m] > 0) begin mode[m] = M_BLANK; mblank[m] = 1; bcnt[m] = 0; end
        end else if (AF[m] != 0 && ft) begin
          fcnt[m] = (fcnt[m] + 1 == AF[m]) ? 0 : fcnt[m] + 1;
        end
      end else begin
        if (ft) begin
          bcnt[m]++;
          if (bcnt[m] == BF[m]) begin
            mode[m] = M_SHOW; mblank[m] = 0; bcnt[m] = 0; fcnt[m] = 0;
          end
        end
      end
    end
    accRd = accR; accLd = accL;
    if (hr[1] != accR) begin runR++; if (runR == DEB) begin accR = hr[1]; runR = 0; end end
    else runR = 0;
    if (hl[1] != accL) begin runL++; if (runL == DEB) begin accL = hl[1]; runL = 0; end end
    else runL = 0;
    hsw[1] = hsw[0]; hsw[0] = sw;
    hr[1]  = hr[0];  hr[0]  = btnR;
    hl[1]  = hl[0];  hl[0]  = btnL;
  endtask

  task automatic compare_all();
    int gi, gb, ga, gl, gc;
    for (int m = 0; m < 3; m++) begin
      case (m)
        0: begin gi = ifa.screen_idx; gb = ifa.blank; ga = ifa.active; gl = ifa.at_last; gc = ifa.change; end
        1: begin gi = ifb.screen_idx; gb = ifb.blank; ga = ifb.active; gl = ifb.at_last; gc = ifb.change; end
        default: begin gi = ifc.screen_idx; gb = ifc.blank; ga = ifc.active; gl = ifc.at_last; gc = ifc.change; end
      endcase
      chk($sformatf("idx%0d", m), gi, idx[m]);
      chk($sformatf("blank%0d", m), gb, mblank[m]);
      chk($sformatf("active%0d", m), ga, mactive[m]);
      chk($sformatf("at_last%0d", m), gl, (idx[m] == NS - 1) ? 1 : 0);
      chk($sformatf("change%0d", m), gc, mchange[m]);
    end
  endtask

  // Inputs change only at negedge; model steps at posedge, outputs sampled at negedge.
  task automatic step();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic press(input bit right);
    if (right) btnR = 1'b1; else btnL = 1'b1;
    repeat (25) step();
    btnR = 1'b0; btnL = 1'b0;
    repeat (25) step();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin ft = 1'b1; step(); ft = 1'b0; step(); step(); end
  endtask

  task automatic sw_cycle();
    sw = 1'b0; repeat (5) step();
    sw = 1'b1; repeat (5) step();
  endtask

  int hold_r, hold_l, hold_s, nchg, keep;

  initial begin
    npass = 0; ntot = 0;
    reset = 1'b0; sw = 1'b0; btnR = 1'b0; btnL = 1'b0; ft = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_idx", ifa.screen_idx, 0);
    chk("rst_blank", ifa.blank, 1);
    chk("rst_active", ifa.active, 0);
    chk("rst_change", ifa.change, 0);
    chk("rst_at_last", ifa.at_last, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (4) step();

    // enable: two sync flops then the state register
    sw = 1'b1;
    repeat (3) step();
    chk("en_active", ifa.active, 1);
    chk("en_blank", ifa.blank, 0);
    chk("en_change", ifa.change, 0);
    repeat (3) step();

    // clean btnR: update lands 19 clk after the raw edge, then 4-frame blank
    btnR = 1'b1;
    repeat (19) step();
    chk("lat_idx", ifa.screen_idx, 1);
    chk("lat_change", ifa.change, 1);
    for (int k = 0; k < 4; k++) begin
      chk("blank_pre", ifa.blank, 1);
      ft = 1'b1; step(); ft = 1'b0;
      chk(k < 3 ? "blank_hold" : "blank_end", ifa.blank, k < 3 ? 1 : 0);
      step();
    end
    btnR = 1'b0; repeat (30) step();

    // bounce shorter than the debounce window, then a stable press
    keep = ifa.screen_idx;
    for (int k = 0; k < 4; k++) begin
      btnR = 1'b1; repeat (10) step();
      btnR = 1'b0; repeat (10) step();
    end
    btnR = 1'b1; repeat (30) step();
    btnR = 1'b0; repeat (30) step();
    chk("bounce_idx", ifa.screen_idx, keep + 1);
    ticks(5);

    // wrap and no-wrap ends
    sw_cycle();
    press(1'b0);
    chk("wrap_prev_a", ifa.screen_idx, 12);
    chk("nowrap_prev_b", ifb.screen_idx, 0);
    ticks(5);
    press(1'b1);
    chk("wrap_next_a", ifa.screen_idx, 0);
    ticks(5);
    for (int k = 0; k < 11; k++) begin press(1'b1); ticks(5); end
    chk("b_at_12", ifb.screen_idx, 12);
    chk("b_at_last", ifb.at_last, 1);
    press(1'b1);
    chk("nowrap_next_b", ifb.screen_idx, 12);
    ticks(5);

    // auto-advance every 3 frames, and simultaneous presses cancel
    sw_cycle();
    ticks(3);
    chk("auto_1", ifc.screen_idx, 1);
    ticks(3);
    chk("auto_2", ifc.screen_idx, 2);
    keep = ifa.screen_idx;
    btnR = 1'b1; btnL = 1'b1; repeat (25) step();
    btnR = 1'b0; btnL = 1'b0; repeat (25) step();
    chk("both_c", ifc.screen_idx, 2);
    chk("both_a", ifa.screen_idx, keep);

    // disable while blanked at idx 5
    sw_cycle();
    for (int k = 0; k < 4; k++) begin press(1'b1); ticks(5); end
    press(1'b1);
    chk("pre_drop_idx", ifa.screen_idx, 5);
    chk("pre_drop_blank", ifa.blank, 1);
    sw = 1'b0; nchg = 0;
    repeat (5) begin step(); if (ifa.change) nchg++; end
    chk("drop_change_cnt", nchg, 1);
    chk("drop_idx", ifa.screen_idx, 0);
    chk("drop_active", ifa.active, 0);

    // async reset mid-blank
    sw = 1'b1; repeat (5) step();
    press(1'b1);
    chk("pre_rst_blank", ifa.blank, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_idx", ifa.screen_idx, 0);
    chk("arst_blank", ifa.blank, 1);
    chk("arst_active", ifa.active, 0);
    chk("arst_change", ifa.change, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (5) step();

    // randomized run
    hold_r = 1; hold_l = 1; hold_s = 400;
    repeat (5000) begin
      ft = ($urandom_range(0, 7) == 0);
      if (--hold_r == 0) begin btnR = ~btnR; hold_r = $urandom_range(1, 60); end
      if (--hold_l == 0) begin btnL = ~btnL; hold_l = $urandom_range(1, 80); end
      if (--hold_s == 0) begin
        sw = ~sw;
        hold_s = sw ? $urandom_range(300, 1500) : $urandom_range(3, 40);
      end
      step();
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
